// File: rtl/controlador_sumador_if.sv
// Bus bundle between the requesters, the round-robin adder sequencer and the shared adder.
// "slave" is the sequencer's view; "master" is the view of everything around it.
interface controlador_sumador_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [1:0]       modo0;
  logic [1:0]       modo1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic             rci0;
  logic             rci1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             res_rco;
  logic             busy;
  logic             sum_enb;
  logic [1:0]       sum_modo;
  logic [WIDTH-1:0] sum_a;
  logic [WIDTH-1:0] sum_b;
  logic             sum_rci;
  logic [WIDTH-1:0] sum_q;
  logic             sum_rco;

  modport slave (
    input  req0, req1, modo0, modo1, a0, a1, b0, b1, rci0, rci1,
    input  sum_q, sum_rco,
    output gnt0, gnt1, done0, done1, result, res_rco, busy,
    output sum_enb, sum_modo, sum_a, sum_b, sum_rci
  );

  modport master (
    output req0, req1, modo0, modo1, a0, a1, b0, b1, rci0, rci1,
    output sum_q, sum_rco,
    input  gnt0, gnt1, done0, done1, result, res_rco, busy,
    input  sum_enb, sum_modo, sum_a, sum_b, sum_rci
  );
endinterface

// File: rtl/controlador_sumador.sv
// Round-robin sequencer for a shared synchronous adder: picks one of two requesters,
// issues its operation for one cycle, captures Q/RCO and pulses DONE to the owner.
module controlador_sumador #(
  parameter int WIDTH     = 4,
  parameter int PRIO_INIT = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  controlador_sumador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  // Pointer starts at the opposite requester so the first tie goes to PRIO_INIT.
  localparam logic LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_t state;
  logic   owner;
  logic   last;
  logic   winner;

  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) winner = ~last;
  end

  // The sum_* registers double as the latched operands of the current operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= LAST_INIT;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.done0    <= 1'b0;
      bus.done1    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.result   <= '0;
      bus.res_rco  <= 1'b0;
      bus.sum_enb  <= 1'b0;
      bus.sum_modo <= '0;
      bus.sum_a    <= '0;
      bus.sum_b    <= '0;
      bus.sum_rci  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner        <= winner;
            bus.sum_modo <= winner ? bus.modo1 : bus.modo0;
            bus.sum_a    <= winner ? bus.a1    : bus.a0;
            bus.sum_b    <= winner ? bus.b1    : bus.b0;
            bus.sum_rci  <= winner ? bus.rci1  : bus.rci0;
            bus.gnt0     <= ~winner;
            bus.gnt1     <= winner;
            bus.sum_enb  <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          bus.gnt0    <= 1'b0;
          bus.gnt1    <= 1'b0;
          bus.sum_enb <= 1'b0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          bus.result  <= bus.sum_q;
          bus.res_rco <= bus.sum_rco;
          bus.done0   <= ~owner;
          bus.done1   <= owner;
          state       <= RESP;
        end
        RESP: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          last      <= owner;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_sumador.sv
// Bench for controlador_sumador: behavioural adder on the sum_* side, scoreboard of
// expected results checked on every DONE, latency/arbitration checks per scenario.
module tb_controlador_sumador;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controlador_sumador_if #(.WIDTH(W)) bus ();

  controlador_sumador #(.WIDTH(W), .PRIO_INIT(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Shared 4-bit adder: 00 hold, 01 A+B+RCI, 10 A-B-RCI (RCO = borrow), 11 clear.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum_q   <= '0;
      bus.sum_rco <= 1'b0;
    end else if (bus.sum_enb) begin
      case (bus.sum_modo)
        2'b01: {bus.sum_rco, bus.sum_q} <= {1'b0, bus.sum_a} + {1'b0, bus.sum_b} + 5'(bus.sum_rci);
        2'b10: {bus.sum_rco, bus.sum_q} <= {1'b0, bus.sum_a} - {1'b0, bus.sum_b} - 5'(bus.sum_rci);
        2'b11: {bus.sum_rco, bus.sum_q} <= 5'd0;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic         owner;
    logic [W-1:0] q;
    logic         rco;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] mq = '0;
  logic         mrco = 1'b0;

  function automatic void push_exp(input logic who, input logic [1:0] m,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic rci);
    logic [W:0] r;
    case (m)
      2'b01:   r = {1'b0, a} + {1'b0, b} + {4'b0, rci};
      2'b10:   r = {1'b0, a} - {1'b0, b} - {4'b0, rci};
      2'b11:   r = '0;
      default: r = {mrco, mq};
    endcase
    mq   = r[W-1:0];
    mrco = r[W];
    sb.push_back('{who, r[W-1:0], r[W]});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (bus.sum_enb !== (bus.gnt0 | bus.gnt1)) begin
        fails++;
        $display("FAIL sum_enb_issue_only cyc=%0d: sum_enb=%b, required %b", cyc, bus.sum_enb,
                 bus.gnt0 | bus.gnt1);
      end
      tests++;
      if ((bus.gnt0 & bus.gnt1) !== 1'b0 || (bus.done0 & bus.done1) !== 1'b0) begin
        fails++;
        $display("FAIL exclusive cyc=%0d: gnt=%b%b done=%b%b, required no overlap", cyc,
                 bus.gnt1, bus.gnt0, bus.done1, bus.done0);
      end
      if (bus.done0 || bus.done1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done cyc=%0d: done=%b%b, required none", cyc, bus.done1,
                   bus.done0);
        end else begin
          e = sb.pop_front();
          if (bus.done1 !== e.owner || bus.done0 !== ~e.owner ||
              bus.result !== e.q || bus.res_rco !== e.rco) begin
            fails++;
            $display("FAIL done_result cyc=%0d: done=%b%b result=%h rco=%b, required owner=%0d result=%h rco=%b",
                     cyc, bus.done1, bus.done0, bus.result, bus.res_rco, e.owner, e.q, e.rco);
          end
        end
      end
    end
  end

  task automatic drive_req(input logic who, input logic [1:0] m, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic rci);
    if (!who) begin
      bus.req0 = 1'b1; bus.modo0 = m; bus.a0 = a; bus.b0 = b; bus.rci0 = rci;
    end else begin
      bus.req1 = 1'b1; bus.modo1 = m; bus.a1 = a; bus.b1 = b; bus.rci1 = rci;
    end
  endtask

  // One operation: request, check grant latency/operands, scramble operands after GNT.
  task automatic do_op(input logic who, input logic [1:0] m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic rci);
    int start, g, d;
    @(negedge clk);
    drive_req(who, m, a, b, rci);
    push_exp(who, m, a, b, rci);
    start = cyc; g = -1; d = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((who ? bus.gnt1 : bus.gnt0) && g < 0) begin
        g = cyc;
        tests++;
        if (bus.sum_modo !== m || bus.sum_a !== a || bus.sum_b !== b || bus.sum_rci !== rci) begin
          fails++;
          $display("FAIL issue_operands: modo=%b a=%h b=%h rci=%b, required %b %h %h %b",
                   bus.sum_modo, bus.sum_a, bus.sum_b, bus.sum_rci, m, a, b, rci);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.modo0 = 2'($urandom);
        bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.modo1 = 2'($urandom);
      end
      if (who ? bus.done1 : bus.done0) begin
        d = cyc;
        break;
      end
    end
    tests++;
    if (g != start + 1) begin
      fails++;
      $display("FAIL gnt_latency: gnt at %0d, required %0d", g, start + 1);
    end
    tests++;
    if (d != start + 3) begin
      fails++;
      $display("FAIL done_latency: done at %0d, required %0d", d, start + 3);
    end
  endtask

  task automatic test_reset();
    int dones;
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.sum_enb, bus.sum_rci,
         bus.res_rco, bus.result, bus.sum_modo, bus.sum_a, bus.sum_b} !== '0) begin
      fails++;
      $display("FAIL reset_state: gnt=%b%b done=%b%b busy=%b enb=%b result=%h, required all 0",
               bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.busy, bus.sum_enb, bus.result);
    end
    rst_n = 1'b1;
    mq = '0; mrco = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 2'b01, 4'h3, 4'h4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gnt0) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL reset_pre_gnt: gnt0 not seen, required 1");
    end
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    tests++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.sum_enb, bus.sum_rci,
         bus.res_rco, bus.result, bus.sum_modo, bus.sum_a, bus.sum_b} !== '0) begin
      fails++;
      $display("FAIL reset_mid_issue: gnt=%b%b busy=%b enb=%b sum_a=%h, required all 0",
               bus.gnt1, bus.gnt0, bus.busy, bus.sum_enb, bus.sum_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq = '0; mrco = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) dones++;
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL reset_abort: %0d done pulses, required 0", dones);
    end
    drive_req(1'b0, 2'b01, 4'h3, 4'h3, 1'b0);
    drive_req(1'b1, 2'b01, 4'h1, 4'h1, 1'b0);
    push_exp(1'b0, 2'b01, 4'h3, 4'h3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL first_tie: gnt=%b%b, required 01", bus.gnt1, bus.gnt0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_add0();
    do_op(1'b0, 2'b01, 4'h3, 4'h5, 1'b0);
  endtask

  task automatic test_add1_wrap();
    do_op(1'b1, 2'b01, 4'hF, 4'h1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int gw[4];
    int gc[4];
    int dc[4];
    int ng, nd;
    @(negedge clk);
    drive_req(1'b0, 2'b01, 4'h6, 4'h4, 1'b0);
    drive_req(1'b1, 2'b01, 4'h9, 4'h8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 2'b01, 4'h6, 4'h4, 1'b0);
      else            push_exp(1'b1, 2'b01, 4'h9, 4'h8, 1'b1);
    end
    ng = 0; nd = 0;
    for (int i = 0; i < 40 && nd < 4; i++) begin
      @(negedge clk);
      if ((bus.gnt0 || bus.gnt1) && ng < 4) begin
        gw[ng] = bus.gnt1 ? 1 : 0;
        gc[ng] = cyc;
        ng++;
        if (ng == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
      if ((bus.done0 || bus.done1) && nd < 4) begin
        dc[nd] = cyc;
        nd++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tests++;
    if (ng != 4 || nd != 4) begin
      fails++;
      $display("FAIL b2b_count: grants=%0d dones=%0d, required 4 and 4", ng, nd);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (gw[k] != k % 2 || dc[k] != gc[k] + 2 || (k > 0 && gc[k] != gc[k-1] + 4)) begin
          fails++;
          $display("FAIL b2b_op%0d: owner=%0d gnt@%0d done@%0d, required owner=%0d done=gnt+2 gap 4",
                   k, gw[k], gc[k], dc[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_sub_hold_clear();
    do_op(1'b0, 2'b10, 4'h2, 4'h5, 1'b0);
    do_op(1'b0, 2'b00, 4'h7, 4'h1, 1'b0);
    do_op(1'b0, 2'b11, 4'h9, 4'h3, 1'b1);
  endtask

  task automatic test_latch();
    do_op(1'b0, 2'b01, 4'h4, 4'h2, 1'b0);
    do_op(1'b1, 2'b01, 4'hA, 4'h3, 1'b0);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.modo0 = '0;  bus.modo1 = '0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
    bus.rci0 = 1'b0; bus.rci1 = 1'b0;
    test_reset();
    test_add0();
    test_add1_wrap();
    test_back_to_back();
    test_sub_hold_clear();
    test_latch();
    repeat (4) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drained: %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
